// File: rtl/cpu6_memarb_pkg.sv
// Shared definitions for the cpu6 instruction/data memory arbiter.
package cpu6_memarb_pkg;

   localparam int unsigned CPU6_XLEN         = 32;
   localparam int unsigned CPU6_ARB_STARVE_W = 4;

   typedef enum logic {
      CPU6_ARB_LS_PRIO  = 1'b0,
      CPU6_ARB_IF_FORCE = 1'b1
   } cpu6_arb_state_e;

   localparam logic CPU6_ARB_OWNER_IF = 1'b0;
   localparam logic CPU6_ARB_OWNER_LS = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } cpu6_arb_slot_t;

endpackage

// File: rtl/cpu6_dfflr.sv
// Loadable flop with synchronous active-high clear.
module cpu6_dfflr #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lden,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (lden) begin
         q <= d;
      end
   end

endmodule

// File: rtl/cpu6_memarb_rsp_pipe.sv
// MEM_LAT-deep {valid, owner} shift register that follows each RAM read to its data beat.
module cpu6_memarb_rsp_pipe
   import cpu6_memarb_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_owner,
   output logic out_valid,
   output logic out_owner
);

   cpu6_arb_slot_t [MEM_LAT-1:0] stage_q;

   for (genvar i = 0; i < MEM_LAT; i++) begin : g_stage
      cpu6_arb_slot_t stage_d;
      if (i == 0) begin : g_head
         assign stage_d = '{valid: in_valid, owner: in_owner};
      end else begin : g_tail
         assign stage_d = stage_q[i-1];
      end

      cpu6_dfflr #(
         .WIDTH (2)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .lden  (1'b1),
         .d     (stage_d),
         .q     (stage_q[i])
      );
   end

   assign out_valid = stage_q[MEM_LAT-1].valid;
   assign out_owner = stage_q[MEM_LAT-1].owner;

endmodule

// File: rtl/cpu6_memarb.sv
// Single-port RAM arbiter between instruction fetch and load/store, with fetch anti-starvation.
module cpu6_memarb
   import cpu6_memarb_pkg::*;
#(
   parameter int unsigned XLEN       = CPU6_XLEN,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,
   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [XLEN-1:0] ls_addr,
   input  logic [XLEN-1:0] ls_wdata,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [XLEN-1:0] ls_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam logic [CPU6_ARB_STARVE_W-1:0] STARVE_LIM = STARVE_MAX[CPU6_ARB_STARVE_W-1:0];
   localparam logic [CPU6_ARB_STARVE_W-1:0] STARVE_SAT = '1;

   cpu6_arb_state_e              state_q, state_d;
   logic [CPU6_ARB_STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                         pipe_valid, pipe_owner;

   // Grant decision; gated by reset so nothing reaches the RAM while resetting.
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (!reset) begin
         case (state_q)
            CPU6_ARB_IF_FORCE: begin
               if (if_req) begin
                  if_gnt = 1'b1;
               end else if (ls_req) begin
                  ls_gnt = 1'b1;
               end
            end
            default: begin
               if (ls_req) begin
                  ls_gnt = 1'b1;
               end else if (if_req) begin
                  if_gnt = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (if_req && !if_gnt) begin
         starve_cnt_d = (starve_cnt_q == STARVE_SAT) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end

      state_d = state_q;
      case (state_q)
         CPU6_ARB_LS_PRIO: begin
            if (starve_cnt_d >= STARVE_LIM) begin
               state_d = CPU6_ARB_IF_FORCE;
            end
         end
         CPU6_ARB_IF_FORCE: begin
            if (if_gnt || !if_req) begin
               state_d = CPU6_ARB_LS_PRIO;
            end
         end
         default: state_d = CPU6_ARB_LS_PRIO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CPU6_ARB_LS_PRIO;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      mem_req   = if_gnt | ls_gnt;
      mem_we    = ls_gnt & ls_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ls_gnt) begin
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
      end else if (if_gnt) begin
         mem_addr = if_addr;
      end
   end

   cpu6_memarb_rsp_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_rsp_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (mem_req & ~mem_we),
      .in_owner  (ls_gnt),
      .out_valid (pipe_valid),
      .out_owner (pipe_owner)
   );

   // The pipe's last stage still holds pre-reset reads during the reset cycle itself.
   always_comb begin
      if_rvalid = !reset && pipe_valid && (pipe_owner == CPU6_ARB_OWNER_IF);
      ls_rvalid = !reset && pipe_valid && (pipe_owner == CPU6_ARB_OWNER_LS);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      ls_rdata  = ls_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_cpu6_memarb.sv
// Bench for cpu6_memarb: two instances (MEM_LAT 1 and 3) share stimulus, each with its own RAM.
module tb_cpu6_memarb;

   localparam int STARVE_MAX = 3;
   localparam int LAT0       = 1;
   localparam int LAT1       = 3;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;

   logic        if_gnt [2], if_rvalid [2], ls_gnt [2], ls_rvalid [2], mem_req [2], mem_we [2];
   logic [31:0] if_rdata [2], ls_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cpu6_memarb #(.XLEN(32), .MEM_LAT(LAT0), .STARVE_MAX(STARVE_MAX)) u_dut0 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]),
      .if_rdata(if_rdata[0]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt[0]),
      .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
      .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   cpu6_memarb #(.XLEN(32), .MEM_LAT(LAT1), .STARVE_MAX(STARVE_MAX)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]),
      .if_rdata(if_rdata[1]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt[1]),
      .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
      .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic logic [31:0] init_word(input int idx);
      case (idx)
         64:      return 32'hDEADBEEF;
         128:     return 32'hCAFE0200;
         4:       return 32'h0F0E0010;
         default: return 32'hA500_0000 | 32'(idx);
      endcase
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // RAM models: writes land on the edge, reads return MEM_LAT cycles after the request.
   logic [31:0] ram [2][256];
   logic [31:0] rd_line [2][4];
   logic        ram_ready = 1'b0;

   assign mem_rdata[0] = rd_line[0][LAT0-1];
   assign mem_rdata[1] = rd_line[1][LAT1-1];

   always @(posedge clk) begin
      ram_ready <= 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[k][i] <= init_word(i);
         end else if (mem_req[k] && mem_we[k]) begin
            ram[k][mem_addr[k][9:2]] <= mem_wdata[k];
         end
         for (int s = 3; s > 0; s--) rd_line[k][s] <= rd_line[k][s-1];
         rd_line[k][0] <= (mem_req[k] && !mem_we[k]) ? ram[k][mem_addr[k][9:2]] : 32'hBADBAD00;
      end
   end

   // Reference model: arbitration from the denied-fetch count, reads as a due-time queue.
   typedef struct {
      int          due;
      logic        owner;
      logic [31:0] data;
   } rsp_t;

   rsp_t        pq [2][$];
   logic [31:0] shadow [256];
   int          cyc    = 0;
   int          denied = 0;

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
   end

   always @(negedge clk) begin
      logic        e_if, e_ls, e_we, e_irv, e_lrv;
      logic [31:0] e_addr, e_wdata, e_rd;
      e_if = 1'b0;
      e_ls = 1'b0;
      if (!reset) begin
         e_if = if_req && (denied >= STARVE_MAX || !ls_req);
         e_ls = ls_req && !e_if;
      end
      e_we    = e_ls && ls_we;
      e_addr  = e_if ? if_addr : (e_ls ? ls_addr : 32'h0);
      e_wdata = e_ls ? ls_wdata : 32'h0;
      for (int k = 0; k < 2; k++) begin
         e_irv = 1'b0;
         e_lrv = 1'b0;
         e_rd  = 32'h0;
         if (!reset && pq[k].size() > 0 && pq[k][0].due == cyc) begin
            if (pq[k][0].owner) e_lrv = 1'b1;
            else e_irv = 1'b1;
            e_rd = pq[k][0].data;
         end
         chk1($sformatf("u%0d if_gnt", k), if_gnt[k], e_if);
         chk1($sformatf("u%0d ls_gnt", k), ls_gnt[k], e_ls);
         chk1($sformatf("u%0d mem_req", k), mem_req[k], e_if || e_ls);
         chk1($sformatf("u%0d mem_we", k), mem_we[k], e_we);
         chk32($sformatf("u%0d mem_addr", k), mem_addr[k], e_addr);
         chk32($sformatf("u%0d mem_wdata", k), mem_wdata[k], e_wdata);
         chk1($sformatf("u%0d if_rvalid", k), if_rvalid[k], e_irv);
         chk1($sformatf("u%0d ls_rvalid", k), ls_rvalid[k], e_lrv);
         chk32($sformatf("u%0d if_rdata", k), if_rdata[k], e_irv ? e_rd : 32'h0);
         chk32($sformatf("u%0d ls_rdata", k), ls_rdata[k], e_lrv ? e_rd : 32'h0);
         if (reset) begin
            pq[k].delete();
         end else begin
            if (pq[k].size() > 0 && pq[k][0].due == cyc) void'(pq[k].pop_front());
            if ((e_if || e_ls) && !e_we) begin
               pq[k].push_back('{due: cyc + ((k == 0) ? LAT0 : LAT1), owner: e_ls,
                                 data: shadow[e_addr[9:2]]});
            end
         end
      end
      if (reset) begin
         denied = 0;
      end else begin
         if (e_we) shadow[e_addr[9:2]] = ls_wdata;
         if (e_if || !if_req) denied = 0;
         else denied++;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         tick();
         if_req = 1'b0;
         ls_req = 1'b0;
         ls_we  = 1'b0;
         sample();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic exp_if;
      reset    = 1'b1;
      if_req   = 1'b1;
      ls_req   = 1'b1;
      if_addr  = 32'h100;
      ls_addr  = 32'h200;
      ls_we    = 1'b0;
      ls_wdata = 32'h0;

      // Reset with both requests pending: everything reads 0.
      for (int c = 0; c < 3; c++) begin
         sample();
         for (int k = 0; k < 2; k++) begin
            chk1("rst if_gnt", if_gnt[k], 1'b0);
            chk1("rst ls_gnt", ls_gnt[k], 1'b0);
            chk1("rst mem_req", mem_req[k], 1'b0);
            chk32("rst mem_addr", mem_addr[k], 32'h0);
         end
      end
      tick();
      reset  = 1'b0;
      if_req = 1'b0;
      ls_req = 1'b0;
      sample();
      chk1("idle mem_req", mem_req[0], 1'b0);
      chk1("idle if_rvalid", if_rvalid[0], 1'b0);
      idle(1);
      chk1("idle ls_rvalid", ls_rvalid[0], 1'b0);

      // Fetch only.
      for (int c = 0; c < 3; c++) begin
         tick();
         if_req  = 1'b1;
         if_addr = 32'h100;
         sample();
         chk1("fetch if_gnt", if_gnt[0], 1'b1);
         chk32("fetch mem_addr", mem_addr[0], 32'h100);
         chk1("fetch if_rvalid", if_rvalid[0], c > 0);
         if (c > 0) chk32("fetch if_rdata", if_rdata[0], 32'hDEADBEEF);
      end
      tick();
      if_req = 1'b0;
      sample();
      chk1("fetch last if_rvalid", if_rvalid[0], 1'b1);
      chk32("fetch last if_rdata", if_rdata[0], 32'hDEADBEEF);
      idle(3);

      // Conflict: load wins, fetch follows.
      tick();
      if_req  = 1'b1;
      if_addr = 32'h10;
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h200;
      sample();
      chk1("conf c0 ls_gnt", ls_gnt[0], 1'b1);
      chk1("conf c0 if_gnt", if_gnt[0], 1'b0);
      tick();
      ls_req = 1'b0;
      sample();
      chk1("conf c1 if_gnt", if_gnt[0], 1'b1);
      chk32("conf c1 mem_addr", mem_addr[0], 32'h10);
      chk1("conf c1 ls_rvalid", ls_rvalid[0], 1'b1);
      chk32("conf c1 ls_rdata", ls_rdata[0], 32'hCAFE0200);
      tick();
      if_req = 1'b0;
      sample();
      chk1("conf c2 if_rvalid", if_rvalid[0], 1'b1);
      chk32("conf c2 if_rdata", if_rdata[0], 32'h0F0E0010);
      chk1("conf c2 ls_rvalid", ls_rvalid[0], 1'b0);
      idle(3);

      // Starvation: continuous ls traffic alternating load/store, fetch held.
      tick();
      if_req   = 1'b1;
      if_addr  = 32'h300;
      ls_req   = 1'b1;
      ls_we    = 1'b0;
      ls_addr  = 32'h200;
      ls_wdata = 32'h5000_0000;
      for (int k = 0; k < 14; k++) begin
         sample();
         exp_if = (k == 3) || (k == 7) || (k == 11);
         chk1("starve if_gnt", if_gnt[0], exp_if);
         chk1("starve ls_gnt", ls_gnt[0], !exp_if);
         chk1("starve cnt<=3", u_dut0.starve_cnt_q <= 4'd3, 1'b1);
         tick();
         if (!exp_if) begin
            ls_we    = ~ls_we;
            ls_wdata = 32'h5000_0000 + 32'(k);
            ls_addr  = ls_we ? 32'h80 : 32'h200;
         end
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      ls_we  = 1'b0;
      sample();
      idle(3);

      // Store, no response, then read back.
      tick();
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = 32'h40;
      ls_wdata = 32'h12345678;
      sample();
      chk1("store ls_gnt", ls_gnt[0], 1'b1);
      chk1("store mem_we", mem_we[0], 1'b1);
      chk32("store mem_addr", mem_addr[0], 32'h40);
      chk32("store mem_wdata", mem_wdata[0], 32'h12345678);
      for (int c = 0; c < 3; c++) begin
         tick();
         ls_req = 1'b0;
         ls_we  = 1'b0;
         sample();
         chk1("store no ls_rvalid u0", ls_rvalid[0], 1'b0);
         chk1("store no ls_rvalid u1", ls_rvalid[1], 1'b0);
      end
      tick();
      ls_req = 1'b1;
      sample();
      chk1("reload mem_we", mem_we[0], 1'b0);
      tick();
      ls_req = 1'b0;
      sample();
      chk1("reload ls_rvalid u0", ls_rvalid[0], 1'b1);
      chk32("reload ls_rdata u0", ls_rdata[0], 32'h12345678);
      idle(1);
      idle(1);
      chk1("reload ls_rvalid u1", ls_rvalid[1], 1'b1);
      chk32("reload ls_rdata u1", ls_rdata[1], 32'h12345678);
      idle(2);

      // Reset with two reads in flight.
      tick();
      if_req  = 1'b1;
      if_addr = 32'h100;
      sample();
      chk1("mid if_gnt", if_gnt[0], 1'b1);
      tick();
      if_req  = 1'b0;
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h200;
      sample();
      chk1("mid ls_gnt", ls_gnt[0], 1'b1);
      chk1("mid u0 if_rvalid", if_rvalid[0], 1'b1);
      tick();
      ls_req = 1'b0;
      reset  = 1'b1;
      sample();
      chk1("mid rst u0 ls_rvalid", ls_rvalid[0], 1'b0);
      tick();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         sample();
         chk1("mid u1 if_rvalid", if_rvalid[1], 1'b0);
         chk1("mid u1 ls_rvalid", ls_rvalid[1], 1'b0);
         chk1("mid u0 ls_rvalid", ls_rvalid[0], 1'b0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu6_memarb.md
Name: cpu6_memarb

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store port.
- Each cycle it selects at most one requester and drives that request to the RAM.
- It tracks in-flight reads so each read's data returns to the correct requester.
- Data accesses normally win; an anti-starvation counter forces a fetch grant after a bounded number of denied fetch cycles. The core uses each port's gnt to derive its fetch or memory stall.

Parameters:
XLEN, 32, address/data width (matches CPU6_XLEN)
MEM_LAT, 1, RAM read latency in cycles from accepted request to rdata valid (1..4)
STARVE_MAX, 3, consecutive denied fetch cycles after which fetch gets priority (1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_gnt
if_addr  input  XLEN  fetch address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch read data valid
if_rdata  output  XLEN  fetch read data
ls_req  input  1  load/store request, held until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  XLEN  load/store address
ls_wdata  input  XLEN  store data
ls_gnt  output  1  load/store request accepted this cycle
ls_rvalid  output  1  load read data valid (never asserted for stores)
ls_rdata  output  XLEN  load read data
mem_req  output  1  RAM access this cycle
mem_we  output  1  RAM write enable
mem_addr  output  XLEN  RAM address
mem_wdata  output  XLEN  RAM write data
mem_rdata  input  XLEN  RAM read data, valid MEM_LAT cycles after mem_req with mem_we=0

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Grant path: grant is combinational from the current requests and registered state. mem_req = if_gnt | ls_gnt, and at most one of if_gnt/ls_gnt is high in any cycle.
- Mux: the mem_* outputs follow the granted port. When idle, mem_addr, mem_wdata and mem_we are 0.
- Arbiter states: ARB_LS_PRIO (default) and ARB_IF_FORCE.
  - ARB_LS_PRIO: if ls_req, grant ls; else if if_req, grant if.
  - ARB_IF_FORCE: if if_req, grant if; else if ls_req, grant ls.
- Starvation counter starve_cnt, width 4:
  - Increments by 1, saturating at 15, in each cycle with if_req=1 and if_gnt=0.
  - Clears to 0 on any cycle with if_gnt=1 or if_req=0.
- State transitions:
  - ARB_LS_PRIO -> ARB_IF_FORCE when, at the clock edge, the next starve_cnt value is >= STARVE_MAX.
  - ARB_IF_FORCE -> ARB_LS_PRIO on the clock edge after the cycle in which if_gnt=1, or after a cycle with if_req=0.
  - Consequence with STARVE_MAX=3: under continuous ls_req, fetch is granted every 4th cycle.
- Response tracking: a shift register of MEM_LAT stages, each holding {valid, owner}.
  - Stage 0 loads {mem_req & ~mem_we, ls_gnt}. Stages shift every cycle, with no back-pressure.
  - At the last stage: if valid & owner=ls, assert ls_rvalid with ls_rdata=mem_rdata; if valid & owner=if, assert if_rvalid with if_rdata=mem_rdata.
  - Both rvalids are never high in the same cycle.
  - rdata outputs are 0 whenever the matching rvalid is 0.
- Stores: complete in the grant cycle. They produce no response and occupy no response-slot valid bit.
- Throughput: one access per cycle. Reads may be back-to-back and interleaved across owners; order is preserved per the pipe.
- Reset:
  - State = ARB_LS_PRIO, starve_cnt = 0, all pipe valid bits = 0.
  - All outputs read 0 during reset: gnts, rvalids, rdata and mem_*. Grants are gated by reset.
  - Reset arriving mid-operation discards in-flight reads: no rvalid for them after reset, even though the RAM may still return data.
- Simultaneous events:
  - if_req & ls_req in ARB_LS_PRIO -> ls wins.
  - In ARB_IF_FORCE -> if wins, and the denied ls_req does not affect any counter.
- Request stability: a requester holding req must keep addr, we and wdata stable until its gnt. The block does not latch ungranted requests.

Decomposition:
- Shared package/defines: CPU6_XLEN; arbiter state encodings CPU6_ARB_LS_PRIO=1'b0 and CPU6_ARB_IF_FORCE=1'b1; owner encodings CPU6_ARB_OWNER_IF=1'b0 and CPU6_ARB_OWNER_LS=1'b1; the starvation counter width.
- One natural sub-module: cpu6_memarb_rsp_pipe, the MEM_LAT-deep {valid, owner} shift register with synchronous reset. Build it from the existing cpu6_dfflr flops.

Test Plan:
- Reset/idle: hold reset 3 cycles with if_req=ls_req=1 -> all outputs 0. After release with no reqs -> mem_req=0 and no rvalid.
- Fetch only: MEM_LAT=1, if_req with if_addr=0x100 for 3 cycles, RAM word = 0xDEADBEEF -> if_gnt=1 each cycle, mem_addr=0x100, if_rvalid=1 one cycle after each grant with if_rdata=0xDEADBEEF.
- Conflict: cycle 0, if_req with addr 0x10 and ls load from 0x200 -> ls_gnt=1 and if_gnt=0 in cycle 0. Fetch is granted in cycle 1. ls_rvalid in cycle 1, if_rvalid in cycle 2, each carrying its own data.
- Starvation: ls_req held continuously (alternating loads/stores), if_req held, STARVE_MAX=3 -> if_gnt in cycles 3, 7, 11 and ls_gnt in all other cycles. starve_cnt never exceeds 3.
- Store: ls_we=1, addr 0x40, wdata 0x12345678 -> mem_we=1 with matching addr/wdata in the grant cycle. No ls_rvalid follows. A subsequent load from 0x40 returns 0x12345678.
- Reset mid-flight: MEM_LAT=3, grant two reads, assert reset in the next cycle -> neither if_rvalid nor ls_rvalid is ever asserted for those reads.
